md6_pad_responder: RTL and testbench

//   Emulates a Sega Mega Drive 6-button pad on the DB9 joystick pins. It is the
//   pad end of the select-strobe protocol that our joystick reader drives on

---
 rtl/md6_pad_responder_if.sv | 22 ++
 rtl/md6_pad_responder.sv | 114 +++++++++++
 tb/tb_md6_pad_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/md6_pad_responder_if.sv
// Pad-side bundle for md6_pad_responder: select strobe and buttons in, DB9 pin levels out.
// The host (reader or bench) takes the master modport; the pad emulator takes the slave.
interface md6_pad_responder_if;
  logic        sel_i;
  logic [11:0] btn_i;
  logic        up_o;
  logic        down_o;
  logic        left_o;
  logic        right_o;
  logic        p6_o;
  logic        p9_o;

  modport master (
    output sel_i, btn_i,
    input  up_o, down_o, left_o, right_o, p6_o, p9_o
  );

  modport slave (
    input  sel_i, btn_i,
    output up_o, down_o, left_o, right_o, p6_o, p9_o
  );
endinterface

// File: rtl/md6_pad_responder.sv
// Mega Drive pad emulator: answers the TH select strobe with active-low DB9 pin levels.
// Define MD_PAD_SIXBTN_EN for the 6-button protocol; left undefined, a 3-button pad is built.
module md6_pad_responder #(
  parameter int TIMEOUT_CYC = 16500
) (
  input logic                clk_i,
  input logic                res_n_i,
  md6_pad_responder_if.slave pad
);

  logic        r_sel_meta;
  logic        r_sel_s;
  logic        r_sel_d;
  logic [5:0]  r_pins;
  logic [5:0]  w_pins_next;
  logic [11:0] w_btn;

  assign w_btn = pad.btn_i;

  // sel_i is asynchronous to clk_i; r_sel_d keeps the previous synced level for edge detection
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_sel_meta <= 1'b1;
      r_sel_s    <= 1'b1;
      r_sel_d    <= 1'b1;
    end else begin
      r_sel_meta <= pad.sel_i;
      r_sel_s    <= r_sel_meta;
      r_sel_d    <= r_sel_s;
    end
  end

`ifdef MD_PAD_SIXBTN_EN
  localparam int         CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] FC_ID  = 3'd3;
  localparam logic [2:0] FC_MAX = 3'd4;

  logic          w_fall;
  logic          w_rise;
  logic          w_expire;
  logic [2:0]    w_fc_next;
  logic [2:0]    r_fc;
  logic [CW-1:0] r_to_cnt;

  assign w_fall   = r_sel_d & ~r_sel_s;
  assign w_rise   = ~r_sel_d & r_sel_s;
  assign w_expire = (r_to_cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_to_cnt <= '0;
      r_fc     <= 3'd0;
    end else begin
      if (w_fall || w_rise) begin
        r_to_cnt <= '0;
      end else if (!w_expire) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end
      r_fc <= w_fc_next;
    end
  end

  // An edge landing in the same cycle as expiry takes priority over the phase reset
  always_comb begin
    w_fc_next = r_fc;
    if (w_fall) begin
      if (w_expire) begin
        w_fc_next = 3'd1;
      end else if (r_fc != FC_MAX) begin
        w_fc_next = r_fc + 3'd1;
      end
    end else if (w_expire && !w_rise) begin
      w_fc_next = 3'd0;
    end
  end
`else
  logic w_unused_btn;
  assign w_unused_btn = &{1'b0, w_btn[11:8]};
`endif

  // Output map uses the upcoming phase so a strobe edge and its new phase appear together
  always_comb begin
    if (r_sel_s) begin
      w_pins_next = {~w_btn[0], ~w_btn[1], ~w_btn[2], ~w_btn[3], ~w_btn[4], ~w_btn[5]};
    end else begin
      w_pins_next = {~w_btn[0], ~w_btn[1], 2'b00, ~w_btn[6], ~w_btn[7]};
    end
`ifdef MD_PAD_SIXBTN_EN
    if (r_sel_s && w_fc_next == FC_ID) begin
      w_pins_next[5:2] = {~w_btn[8], ~w_btn[9], ~w_btn[10], ~w_btn[11]};
    end else if (!r_sel_s && w_fc_next == FC_ID) begin
      w_pins_next[5:2] = 4'b0000;
    end else if (!r_sel_s && w_fc_next == FC_MAX) begin
      w_pins_next[5:2] = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_pins <= 6'b111111;
    end else begin
      r_pins <= w_pins_next;
    end
  end

  assign pad.up_o    = r_pins[5];
  assign pad.down_o  = r_pins[4];
  assign pad.left_o  = r_pins[3];
  assign pad.right_o = r_pins[2];
  assign pad.p6_o    = r_pins[1];
  assign pad.p9_o    = r_pins[0];

endmodule

// File: tb/tb_md6_pad_responder.sv
// Scoreboard bench for md6_pad_responder; expectations follow the build selected by MD_PAD_SIXBTN_EN.
module tb_md6_pad_responder;

  localparam int TO = 64;
`ifdef MD_PAD_SIXBTN_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif

  logic clk = 1'b0;
  logic resN;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   modelFc;
  logic [5:0] scoreboard[$];

  always #5 clk = ~clk;

  md6_pad_responder_if padIf ();

  md6_pad_responder #(.TIMEOUT_CYC(TO)) dut (
    .clk_i   (clk),
    .res_n_i (resN),
    .pad     (padIf)
  );

  function automatic logic [5:0] readPins();
    return {padIf.up_o, padIf.down_o, padIf.left_o, padIf.right_o, padIf.p6_o, padIf.p9_o};
  endfunction

  // Reference pin map {up,down,left,right,p6,p9} for a strobe level, phase and button set
  function automatic logic [5:0] refPins(input logic sel, input int fc, input logic [11:0] b);
    logic [11:0] n;
    n = ~b;
    if (sel) begin
      if (SIX && fc == 3) return {n[8], n[9], n[10], n[11], n[4], n[5]};
      return {n[0], n[1], n[2], n[3], n[4], n[5]};
    end
    if (SIX && fc == 3) return {4'b0000, n[6], n[7]};
    if (SIX && fc >= 4) return {4'b1111, n[6], n[7]};
    return {n[0], n[1], 2'b00, n[6], n[7]};
  endfunction

  task automatic doReset();
    @(negedge clk);
    resN = 1'b0;
    padIf.sel_i = 1'b1;
    modelFc = 0;
    repeat (2) @(negedge clk);
    resN = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] expPins;
    logic [5:0] got;
    @(negedge clk);
    resN = 1'b0;
    padIf.sel_i = 1'b1;
    padIf.btn_i = 12'h000;
    modelFc = 0;
    scoreboard.push_back(6'b111111);
    repeat (2) @(negedge clk);
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %b want %b", got, expPins);
    end
    resN = 1'b1;
  endtask

  task automatic test_button_latency();
    logic [5:0] expPins;
    logic [5:0] got;
    @(negedge clk);
    padIf.btn_i = 12'h011;
    scoreboard.push_back(6'b011101);
    @(negedge clk);
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL button_latency: got %b want %b", got, expPins);
    end
  endtask

  task automatic test_select_low();
    logic [5:0] expPins;
    logic [5:0] got;
    padIf.btn_i = 12'h0C0;
    repeat (2) @(negedge clk);
    padIf.sel_i = 1'b0;
    scoreboard.push_back(refPins(1'b1, modelFc, 12'h0C0));
    modelFc = 1;
    scoreboard.push_back(6'b110000);
    repeat (2) @(negedge clk);
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL select_low_early: got %b want %b", got, expPins);
    end
    @(negedge clk);
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL select_low_3edges: got %b want %b", got, expPins);
    end
  endtask

  task automatic test_full_strobe();
    logic [5:0] expPins;
    logic [5:0] got;
    doReset();
    padIf.btn_i = 12'h900;
    for (int i = 0; i < 8; i++) begin
      padIf.sel_i = (i % 2 == 0);
      if (i % 2 == 1 && modelFc < 4) modelFc++;
      scoreboard.push_back(refPins(padIf.sel_i, modelFc, padIf.btn_i));
      repeat (8) @(negedge clk);
      expPins = scoreboard.pop_front();
      got = readPins();
      nCompared++;
      if (got !== expPins) begin
        nMismatched++;
        $display("[TB] FAIL strobe_level%0d: got %b want %b", i, got, expPins);
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0] expPins;
    logic [5:0] got;
    padIf.btn_i = 12'h901;
    padIf.sel_i = 1'b1;
    repeat (70) @(negedge clk);
    modelFc = 0;
    scoreboard.push_back(refPins(1'b1, modelFc, padIf.btn_i));
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL timeout_high: got %b want %b", got, expPins);
    end
    padIf.sel_i = 1'b0;
    modelFc = 1;
    scoreboard.push_back(refPins(1'b0, modelFc, padIf.btn_i));
    repeat (8) @(negedge clk);
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL timeout_restart_low: got %b want %b", got, expPins);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [5:0] expPins;
    logic [5:0] got;
    doReset();
    padIf.btn_i = 12'h0C0;
    for (int i = 0; i < 6; i++) begin
      padIf.sel_i = (i % 2 == 0);
      if (i % 2 == 1) modelFc++;
      repeat (8) @(negedge clk);
    end
    scoreboard.push_back(refPins(1'b0, modelFc, padIf.btn_i));
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL third_low: got %b want %b", got, expPins);
    end
    resN = 1'b0;
    padIf.sel_i = 1'b1;
    modelFc = 0;
    scoreboard.push_back(6'b111111);
    #1;
    expPins = scoreboard.pop_front();
    got = readPins();
    nCompared++;
    if (got !== expPins) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: got %b want %b", got, expPins);
    end
    @(negedge clk);
    resN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      padIf.sel_i = (i % 2 == 1);
      if (i % 2 == 0) modelFc++;
      scoreboard.push_back(refPins(padIf.sel_i, modelFc, padIf.btn_i));
      repeat (8) @(negedge clk);
      expPins = scoreboard.pop_front();
      got = readPins();
      nCompared++;
      if (got !== expPins) begin
        nMismatched++;
        $display("[TB] FAIL fresh_seq_level%0d: got %b want %b", i, got, expPins);
      end
    end
  endtask

  initial begin
    resN = 1'b1;
    padIf.sel_i = 1'b1;
    padIf.btn_i = 12'h000;
    modelFc = 0;
    $display("[TB] six-button build: %0d", SIX);
    test_reset();
    test_button_latency();
    test_select_low();
    test_full_strobe();
    test_timeout();
    test_reset_mid_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
